// File: rtl/param_ring_counter.sv
// rtl/param_ring_counter.sv - parametrised one-hot ring / Johnson counter with wrap pulse
// Optional feature macro: RING_SELF_CORRECT_EN (re-home illegal states on an enabled cycle)
module param_ring_counter #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap
);

   logic [WIDTH-1:0] home;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      home    = mode ? '0 : SEED;
      shifted = q;
      case ({mode, dir})
         2'b00:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
         2'b01:   shifted = {q[0], q[WIDTH-1:1]};
         2'b10:   shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
         default: shifted = {~q[0], q[WIDTH-1:1]};
      endcase
   end

`ifdef RING_SELF_CORRECT_EN
   // Ring is legal only when one-hot; Johnson only with at most one 0/1 boundary.
   logic illegal;
   int   ones;
   int   edges;

   always_comb begin
      ones  = 0;
      edges = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (q[i]) ones = ones + 1;
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (q[i] != q[i+1]) edges = edges + 1;
      end
      illegal = mode ? (edges > 1) : (ones != 1);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         q    <= home;
         wrap <= 1'b0;
      end else if (load) begin
         q    <= load_val;
         wrap <= 1'b0;
      end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
         if (illegal) begin
            q    <= home;
            wrap <= 1'b0;
         end else begin
            q    <= shifted;
            wrap <= (shifted == home);
         end
`else
         q    <= shifted;
         wrap <= (shifted == home);
`endif
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_ring_counter.sv
// tb/tb_param_ring_counter.sv - scoreboard bench for param_ring_counter against an arithmetic model
// Honours RING_SELF_CORRECT_EN in the reference model when defined.
module tb_param_ring_counter;

   localparam int W   = 4;
   localparam int TOP = 1 << (W - 1);

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic         mode = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q;
   logic         wrap;

   typedef struct {
      logic [W-1:0] q;
      logic         w;
      string        tag;
   } exp_t;

   exp_t         sb[$];
   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] m_q = '0;

   param_ring_counter #(.WIDTH(W), .SEED(W'(1))) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
      .load(load), .load_val(load_val), .q(q), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // Next state as plain integer arithmetic: doubling/halving plus a fed-in end bit.
   function automatic logic [W-1:0] model_shift(logic [W-1:0] s, logic d, logic m);
      int v;
      int feed;
      v = int'(s);
      if (!d) begin
         feed = m ? 1 - (v / TOP) : v / TOP;
         v    = (v * 2) % (2 * TOP) + feed;
      end else begin
         feed = m ? 1 - (v % 2) : v % 2;
         v    = v / 2 + feed * TOP;
      end
      return W'(v);
   endfunction

   function automatic bit model_illegal(logic [W-1:0] s, logic m);
      int edges;
      edges = 0;
      for (int i = 0; i < W - 1; i++) if (s[i] != s[i+1]) edges++;
      return m ? (edges > 1) : ($countones(s) != 1);
   endfunction

   task automatic check_val(string name, logic [W-1:0] act, logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the negedge and push the model's prediction.
   task automatic step(string tag, logic r, logic e, logic d, logic m, logic l, logic [W-1:0] lv);
      exp_t         x;
      logic [W-1:0] h;
      logic         w;
      @(negedge clk);
      rst = r; en = e; dir = d; mode = m; load = l; load_val = lv;
      h = m ? '0 : W'(1);
      w = 1'b0;
      if (!r)       m_q = h;
      else if (l)   m_q = lv;
      else if (e) begin
`ifdef RING_SELF_CORRECT_EN
         if (model_illegal(m_q, m)) m_q = h;
         else begin
            m_q = model_shift(m_q, d, m);
            w   = (m_q == h);
         end
`else
         m_q = model_shift(m_q, d, m);
         w   = (m_q == h);
`endif
      end
      x.q = m_q; x.w = w; x.tag = tag;
      sb.push_back(x);
   endtask

   // Monitor: the counter presents a new state every cycle, compare it away from the edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         check_val({x.tag, ".q"}, q, x.q);
         check_val({x.tag, ".wrap"}, W'(wrap), W'(x.w));
      end
   end

   initial begin
      // 1: ring reset and left rotation
      step("reset_ring", 0, 0, 0, 0, 0, '0);
      step("reset_ring", 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 4; i++) step("ring_left", 1, 1, 0, 0, 0, '0);
      // 2: ring right rotation
      for (int i = 0; i < 4; i++) step("ring_right", 1, 1, 1, 0, 0, '0);
      // 3: Johnson reset and full period
      step("reset_johnson", 0, 0, 0, 1, 0, '0);
      for (int i = 0; i < 8; i++) step("johnson_left", 1, 1, 0, 1, 0, '0);
      for (int i = 0; i < 8; i++) step("johnson_right", 1, 1, 1, 1, 0, '0);
      // 4: load beats enable, reset beats load
      step("load", 1, 1, 0, 0, 1, 4'b0100);
      step("after_load", 1, 1, 0, 0, 0, '0);
      step("reset_over_load", 0, 1, 0, 0, 1, 4'b0100);
      // 5: hold, then a reset with no effect before the edge
      step("load2", 1, 0, 0, 0, 1, 4'b0100);
      for (int i = 0; i < 3; i++) step("hold", 1, 0, 0, 0, 0, '0);
      step("mid_reset", 0, 0, 0, 0, 0, '0);
      #2;
      check_val("reset_not_async", q, 4'b0100);
      // 6: illegal patterns in both modes
      step("ill_load_ring", 1, 0, 0, 0, 1, 4'b0110);
      step("ill_ring_shift", 1, 1, 0, 0, 0, '0);
      step("ill_load_john", 1, 0, 0, 1, 1, 4'b0101);
      step("ill_john_shift", 1, 1, 0, 1, 0, '0);
      step("ring_zero", 1, 0, 0, 0, 1, 4'b0000);
      step("ring_zero_shift", 1, 1, 0, 0, 0, '0);
      // Randomised run with mid-run mode/direction changes
      step("reset_rand", 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 600; i++) begin
         step("random",
              ($urandom_range(0, 39) != 0),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 7) == 0) ? ~dir : dir,
              ($urandom_range(0, 15) == 0) ? ~mode : mode,
              ($urandom_range(0, 14) == 0),
              W'($urandom));
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
